bit_serial_add_ctrl: RTL and testbench

Sequencer that time-shares one external full-adder cell (FAX1-equivalent: inputs A/B/C, outputs YS/YC) to add two WIDTH-bit operands, LSB first.
- One bit per clock; carry kept in a local flop between bits.
- Operands and result are exchanged through ready/valid handshakes.
- Sits between a requesting datapath and a single shared adder cell, for area-minimal arithmetic in generated circuits.

---
 rtl/bit_serial_add_ctrl.sv | 112 +++++++++++
 tb/tb_bit_serial_add_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial adder sequencer: drives one shared full-adder cell LSB first, one bit per clock.
// Optional subtract mode is enabled by defining BIT_SERIAL_ADD_SUB_EN (adds the sub port).
module bit_serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef BIT_SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_ys,
  input  logic             fa_yc
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] sa_reg;
  logic [WIDTH-1:0] sb_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic [CW-1:0]    cnt_reg;

  logic [WIDTH-1:0] b_load;
  logic             carry_load;
  logic [WIDTH-1:0] sum_shift;

`ifdef BIT_SERIAL_ADD_SUB_EN
  // Two's-complement subtract: invert b and inject a carry of one.
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_shift = fa_ys;
    end else begin : g_sum_wn
      assign sum_shift = {fa_ys, sum_reg[WIDTH-1:1]};
    end
  endgenerate

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;

  // Adder cell inputs come only from registers, gated to zero outside RUN.
  assign fa_a = (state_reg == RUN) & sa_reg[0];
  assign fa_b = (state_reg == RUN) & sb_reg[0];
  assign fa_c = (state_reg == RUN) & carry_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      sa_reg    <= '0;
      sb_reg    <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            sa_reg    <= a;
            sb_reg    <= b_load;
            carry_reg <= carry_load;
            cnt_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          sum_reg   <= sum_shift;
          carry_reg <= fa_yc;
          sa_reg    <= sa_reg >> 1;
          sb_reg    <= sb_reg >> 1;
          cnt_reg   <= cnt_reg + CW'(1);
          if (cnt_reg == LAST) begin
            cout_reg  <= fa_yc;
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Directed bench for bit_serial_add_ctrl (WIDTH=8) with a behavioural full-adder cell.
module tb_bit_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       sub_sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       fa_a;
  logic       fa_b;
  logic       fa_c;
  logic       fa_ys;
  logic       fa_yc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // External full-adder cell
  assign fa_ys = fa_a ^ fa_b ^ fa_c;
  assign fa_yc = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

  bit_serial_add_ctrl #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef BIT_SERIAL_ADD_SUB_EN
    .sub      (sub_sel),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .fa_a     (fa_a),
    .fa_b     (fa_b),
    .fa_c     (fa_c),
    .fa_ys    (fa_ys),
    .fa_yc    (fa_yc)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge following the accepting edge.
  task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic c, input logic s);
    a = av; b = bv; cin = c; sub_sel = s; in_valid = 1'b1;
    check("in_ready_before_accept", in_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    $display("accept a=%02h b=%02h cin=%0b sub=%0b", av, bv, c, s);
  endtask

  // Steps through the eight run cycles, capturing fa_a LSB first; ends at the negedge in DONE.
  task automatic run_bits(output logic [7:0] seq);
    for (int i = 0; i < 8; i++) begin
      check("out_valid_low_in_run", out_valid, 1'b0);
      check("in_ready_low_in_run", in_ready, 1'b0);
      seq[i] = fa_a;
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic expect_result(input string tag, input logic [7:0] es, input logic ec);
    check({tag, "_out_valid"}, out_valid, 1'b1);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    $display("result %s sum=%02h cout=%0b (expect %02h/%0b)", tag, sum, cout, es, ec);
  endtask

  task automatic leave_done();
    @(posedge clk); @(negedge clk);
    check("in_ready_after_done", in_ready, 1'b1);
    check("out_valid_after_done", out_valid, 1'b0);
  endtask

  logic [7:0] seq;
  logic [7:0] held_sum;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub_sel = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, 8'h00);
    check("rst_cout", cout, 1'b0);
    check("rst_fa", {fa_a, fa_b, fa_c}, 3'b000);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: 0x5A + 0x3C
    start_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    run_bits(seq);
    check("t1_fa_a_seq", seq, 8'b0101_1010);
    expect_result("t1", 8'h96, 1'b0);
    leave_done();

    // 2: carry out cases
    start_op(8'hFF, 8'h01, 1'b0, 1'b0);
    run_bits(seq);
    expect_result("t2a", 8'h00, 1'b1);
    leave_done();
    start_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    run_bits(seq);
    check("t2b_fa_a_seq", seq, 8'hFF);
    expect_result("t2b", 8'hFF, 1'b1);
    leave_done();

    // 3: backpressure in DONE
    out_ready = 1'b0;
    start_op(8'h21, 8'h43, 1'b1, 1'b0);
    run_bits(seq);
    expect_result("t3", 8'h65, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      check("t3_hold_out_valid", out_valid, 1'b1);
      check("t3_hold_in_ready", in_ready, 1'b0);
      check("t3_hold_sum", {cout, sum}, {1'b0, 8'h65});
      check("t3_hold_fa", {fa_a, fa_b, fa_c}, 3'b000);
    end
    out_ready = 1'b1;
    leave_done();
    check("t3_sum_kept_in_idle", sum, 8'h65);

    // 4: in_valid during RUN is ignored, then accepted after returning to IDLE
    start_op(8'h12, 8'h34, 1'b0, 1'b0);
    a = 8'h11; b = 8'h22; cin = 1'b0; in_valid = 1'b1;
    run_bits(seq);
    expect_result("t4_inflight", 8'h46, 1'b0);
    @(posedge clk); @(negedge clk);
    check("t4_idle_not_accepted_same_edge", in_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check("t4_accepted", in_ready, 1'b0);
    run_bits(seq);
    expect_result("t4_second", 8'h33, 1'b0);
    leave_done();

    // 5: reset mid-RUN aborts the operation
    start_op(8'h0F, 8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("t5_rst_in_ready", in_ready, 1'b1);
    check("t5_rst_out_valid", out_valid, 1'b0);
    check("t5_rst_sum", sum, 8'h00);
    check("t5_rst_cout", cout, 1'b0);
    check("t5_rst_fa", {fa_a, fa_b, fa_c}, 3'b000);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      check("t5_no_out_valid", out_valid, 1'b0);
    end
    start_op(8'h0F, 8'h01, 1'b0, 1'b0);
    run_bits(seq);
    expect_result("t5_fresh", 8'h10, 1'b0);
    leave_done();

`ifdef BIT_SERIAL_ADD_SUB_EN
    // 6: subtract mode
    start_op(8'h10, 8'h01, 1'b0, 1'b1);
    run_bits(seq);
    expect_result("t6a", 8'h0F, 1'b1);
    leave_done();
    start_op(8'h00, 8'h01, 1'b0, 1'b1);
    run_bits(seq);
    expect_result("t6b", 8'hFF, 1'b0);
    leave_done();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
